// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the RV32I/RV64I immediate generator.
// Imported by the decoder, the pipelined top and any core reusing the decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode -> immediate decoder, zero latency, no handshake.
// Sign bit inst_code[31] is replicated up to XLEN; unknown opcodes yield DEFAULT_IMM.
module imm_decode
  import imm_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int unsigned DEFAULT_IMM = 7
) (
  input  logic [31:0]     inst_code,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (inst_code[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{inst_code[31]}}, inst_code[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                 inst_code[30:25], inst_code[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {inst_code[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                 inst_code[20], inst_code[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
    // Signed size cast widens imm32 to XLEN by replicating bit 31.
    imm = illegal ? XLEN'(DEFAULT_IMM) : XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator, 1-cycle latency, main+skid buffer with registered in_ready = !skid_full.
// Define IMM_GEN_ERR_CNT_EN to add err_count/err_sticky tracking illegal entries leaving the block.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          TAG_W       = 8,
  parameter int unsigned DEFAULT_IMM = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  Imm_out,
  output imm_fmt_e         out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef IMM_GEN_ERR_CNT_EN
  ,
  output logic [15:0]      err_count,
  output logic             err_sticky
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode #(
    .XLEN        (XLEN),
    .DEFAULT_IMM (DEFAULT_IMM)
  ) u_decode (
    .inst_code (inst_code),
    .imm       (dec_imm),
    .fmt       (dec_fmt),
    .illegal   (dec_illegal)
  );

  entry_t main_q, main_d, skid_q, skid_d, new_entry;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   in_xfer, out_xfer;

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_vld_q && out_ready;

  always_comb begin
    new_entry.imm     = dec_imm;
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
    new_entry.tag     = in_tag;
  end

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // Full: in_ready is low, so only a drain can happen; skid refills main.
      if (out_xfer) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      case ({in_xfer, out_xfer})
        2'b11: main_d = new_entry;
        2'b01: main_vld_d = 1'b0;
        2'b10: begin
          skid_d     = new_entry;
          skid_vld_d = 1'b1;
        end
        default: ;
      endcase
    end else if (in_xfer) begin
      main_d     = new_entry;
      main_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign Imm_out     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.illegal;

`ifdef IMM_GEN_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;
  logic        err_sticky_q, err_sticky_d;
  logic        err_xfer;

  // Counted at output transfer so entries discarded by flush are never seen.
  assign err_xfer = out_xfer && main_q.illegal;

  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q || err_xfer;
    if (err_xfer && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_count  = err_count_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table, backpressure, flush, async reset, XLEN=64.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst_code = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] imm_out;
  imm_fmt_e    out_fmt;
  logic [7:0]  out_tag;
  logic        out_illegal;
`ifdef IMM_GEN_ERR_CNT_EN
  logic [15:0] err_count;
  logic        err_sticky;
  logic [15:0] err_count64;
  logic        err_sticky64;
`endif

  logic        i64_valid = 1'b0;
  logic        i64_ready;
  logic [31:0] i64_inst = '0;
  logic [7:0]  i64_tag = '0;
  logic        o64_valid;
  logic [63:0] o64_imm;
  imm_fmt_e    o64_fmt;
  logic [7:0]  o64_tag;
  logic        o64_illegal;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .DEFAULT_IMM(7)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst_code(inst_code), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .Imm_out(imm_out),
    .out_fmt(out_fmt), .out_tag(out_tag), .out_illegal(out_illegal)
`ifdef IMM_GEN_ERR_CNT_EN
    , .err_count(err_count), .err_sticky(err_sticky)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .DEFAULT_IMM(7)) dut64 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(i64_valid), .in_ready(i64_ready), .inst_code(i64_inst), .in_tag(i64_tag),
    .out_valid(o64_valid), .out_ready(1'b1), .Imm_out(o64_imm),
    .out_fmt(o64_fmt), .out_tag(o64_tag), .out_illegal(o64_illegal)
`ifdef IMM_GEN_ERR_CNT_EN
    , .err_count(err_count64), .err_sticky(err_sticky64)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  tag;
    logic [31:0] imm;
    imm_fmt_e    fmt;
    logic        ill;
  } vec_t;

  vec_t vecs[11];
  logic [31:0] bp_inst[4];
  logic [7:0]  bp_tag[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int got;
    logic acc;

    vecs[0]  = '{32'hFFF00093, 8'h10, 32'hFFFFFFFF, FMT_I,    1'b0};
    vecs[1]  = '{32'hFE000EE3, 8'h11, 32'hFFFFFFFC, FMT_B,    1'b0};
    vecs[2]  = '{32'h123450B7, 8'h12, 32'h12345000, FMT_U,    1'b0};
    vecs[3]  = '{32'h800000EF, 8'h13, 32'hFFF00000, FMT_J,    1'b0};
    vecs[4]  = '{32'h0000007F, 8'h14, 32'h00000007, FMT_NONE, 1'b1};
    vecs[5]  = '{32'h7E000FA3, 8'h15, 32'h000007FF, FMT_S,    1'b0};
    vecs[6]  = '{32'hFE000FA3, 8'h16, 32'hFFFFFFFF, FMT_S,    1'b0};
    vecs[7]  = '{32'hFFFFF097, 8'h17, 32'hFFFFF000, FMT_U,    1'b0};
    vecs[8]  = '{32'h00400083, 8'h18, 32'h00000004, FMT_I,    1'b0};
    vecs[9]  = '{32'h00000033, 8'h19, 32'h00000007, FMT_NONE, 1'b1};
    vecs[10] = '{32'h7FF00067, 8'hFF, 32'h000007FF, FMT_I,    1'b0};
    for (int k = 0; k < 4; k++) begin
      bp_inst[k] = (32'(k + 1) << 20) | 32'h00000093;
      bp_tag[k]  = 8'hA0 + 8'(k);
    end

    // Reset state
    #12 reset = 1'b0;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm_out), 64'd0);
    chk("rst_fmt", 64'(out_fmt), 64'(FMT_NONE));
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_illegal", 64'(out_illegal), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef IMM_GEN_ERR_CNT_EN
    chk("rst_err_count", 64'(err_count), 64'd0);
`endif

    // Decode sweep at full throughput
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      in_valid  = 1'b1;
      inst_code = vecs[i].inst;
      in_tag    = vecs[i].tag;
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_imm", i), 64'(imm_out), 64'(vecs[i].imm));
      chk($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
      chk($sformatf("v%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drained", 64'(out_valid), 64'd0);
`ifdef IMM_GEN_ERR_CNT_EN
    chk("err_count_2", 64'(err_count), 64'd2);
    chk("err_sticky", 64'(err_sticky), 64'd1);
`endif

    // Backpressure: only two entries fit while out_ready is low
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid  = (idx < 4);
      inst_code = bp_inst[idx % 4];
      in_tag    = bp_tag[idx % 4];
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_hold_tag", 64'(out_tag), 64'(bp_tag[0]));
    chk("bp_hold_imm", 64'(imm_out), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_not_comb", 64'(in_ready), 64'd0);
    got = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      in_valid  = (idx < 4);
      inst_code = bp_inst[idx % 4];
      in_tag    = bp_tag[idx % 4];
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_out%0d_tag", got), 64'(out_tag), 64'(bp_tag[got]));
        chk($sformatf("bp_out%0d_imm", got), 64'(imm_out), 64'(got + 1));
        got++;
      end
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_out", 64'(got), 64'd4);
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Flush with two entries held and an input offered
    out_ready = 1'b0;
    in_valid = 1'b1; inst_code = bp_inst[0]; in_tag = 8'h51;
    tick();
    inst_code = bp_inst[1]; in_tag = 8'h52;
    tick();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; inst_code = bp_inst[2]; in_tag = 8'h53;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_stays_empty", 64'(out_valid), 64'd0);

    // Flush beats a simultaneous accepted input
    in_valid = 1'b1; inst_code = bp_inst[3]; in_tag = 8'h54;
    tick();
    chk("fl2_one_held", 64'(out_valid), 64'd1);
    flush = 1'b1; in_tag = 8'h55;
    chk("fl2_in_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("fl2_input_dropped", 64'(out_valid), 64'd0);

    // Async reset between clock edges
    in_valid = 1'b1; inst_code = bp_inst[0]; in_tag = 8'h61;
    tick();
    in_valid = 1'b0;
    chk("ar_before", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_tag", 64'(out_tag), 64'd0);
    chk("ar_imm", 64'(imm_out), 64'd0);
`ifdef IMM_GEN_ERR_CNT_EN
    chk("ar_err_count", 64'(err_count), 64'd0);
`endif
    #3 reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; inst_code = 32'h00500093; in_tag = 8'h62;
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("ar_first_valid", 64'(out_valid), 64'd1);
    chk("ar_first_tag", 64'(out_tag), 64'h62);
    chk("ar_first_imm", 64'(imm_out), 64'd5);

    // XLEN = 64 instance
    i64_valid = 1'b1; i64_inst = 32'h800000B7; i64_tag = 8'h71;
    tick();
    chk("x64_lui_imm", o64_imm, 64'hFFFFFFFF80000000);
    chk("x64_lui_fmt", 64'(o64_fmt), 64'(FMT_U));
    i64_inst = 32'h7E000FA3; i64_tag = 8'h72;
    tick();
    i64_valid = 1'b0;
    chk("x64_store_imm", o64_imm, 64'h00000000000007FF);
    chk("x64_store_tag", 64'(o64_tag), 64'h72);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
